micro_apb_master: RTL and testbench

MICRO_APB_MASTER -- requirements
Module: micro_apb_master

---
 rtl/micro_apb_pkg.sv | 19 +
 rtl/micro_apb_timeout.sv | 37 +++
 rtl/micro_apb_master.sv | 141 ++++++++++++++
 tb/tb_micro_apb_master.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/micro_apb_pkg.sv
// Shared types and widths for the micro APB master.
package micro_apb_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TO_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } apb_rsp_t;

endpackage

// File: rtl/micro_apb_timeout.sv
// ACCESS wait-state counter: cleared in SETUP, counts stalled ACCESS cycles,
// flags the cycle in which the stall limit is reached (used with MICRO_APB_TIMEOUT_EN).
import micro_apb_pkg::*;

module micro_apb_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_c
);

    logic [TO_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + TO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the LIMIT-th stalled cycle; a ready slave never counts.
    assign expired_c = inc_i && (cnt_q == TO_CNT_W'(LIMIT - 1));

endmodule

// File: rtl/micro_apb_master.sv
// Single-outstanding APB master bridging a valid/ready request/response port.
// Optional ACCESS timeout enabled by defining MICRO_APB_TIMEOUT_EN.
import micro_apb_pkg::*;

module micro_apb_master #(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              apb_psel,
    output logic              apb_penable,
    output logic              apb_pwrite,
    output logic [ADDR_W-1:0] apb_paddr,
    output logic [DATA_W-1:0] apb_pwdata,
    input  logic [DATA_W-1:0] apb_prdata,
    input  logic              apb_pready,
    input  logic              apb_pslverr
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("micro_apb_master: TIMEOUT_CYCLES must be 1..65535");
    end

    apb_state_e        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    apb_rsp_t          rsp_q, rsp_d;
    logic              timeout_c;

`ifdef MICRO_APB_TIMEOUT_EN
    micro_apb_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (state_q == ST_SETUP),
        .inc_i    ((state_q == ST_ACCESS) && !apb_pready),
        .expired_c(timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Next state plus next values of every registered output.
    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rsp_d    = rsp_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d  = ST_SETUP;
                    pwrite_d = req_write;
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb_pready) begin
                    state_d    = ST_RESP;
                    rsp_d.err  = apb_pslverr;
                    rsp_d.rdata = (pwrite_q || apb_pslverr) ? '0 : apb_prdata;
                end else if (timeout_c) begin
                    state_d     = ST_RESP;
                    rsp_d.err   = 1'b1;
                    rsp_d.rdata = '0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the decoded next state.
        req_ready_d = (state_d == ST_IDLE);
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            rsp_valid_q <= rsp_valid_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_q       <= rsp_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign apb_psel    = psel_q;
    assign apb_penable = penable_q;
    assign apb_pwrite  = pwrite_q;
    assign apb_paddr   = paddr_q;
    assign apb_pwdata  = pwdata_q;

endmodule

// File: tb/tb_micro_apb_master.sv
// Self-checking bench for micro_apb_master: directed cases followed by random transfers.
module tb_micro_apb_master;

    localparam int unsigned ADDR_W = 12;
`ifdef MICRO_APB_TIMEOUT_EN
    localparam int TO    = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              apb_psel;
    logic              apb_penable;
    logic              apb_pwrite;
    logic [ADDR_W-1:0] apb_paddr;
    logic [31:0]       apb_pwdata;
    logic [31:0]       apb_prdata;
    logic              apb_pready;
    logic              apb_pslverr;

    int n_assert = 0;
    int n_fail   = 0;

    micro_apb_master #(
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .apb_psel   (apb_psel),
        .apb_penable(apb_penable),
        .apb_pwrite (apb_pwrite),
        .apb_paddr  (apb_paddr),
        .apb_pwdata (apb_pwdata),
        .apb_prdata (apb_prdata),
        .apb_pready (apb_pready),
        .apb_pslverr(apb_pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Expected {err, rdata} of a transfer from the protocol rules alone.
    function automatic logic [32:0] ref_rsp(input logic w, input logic err,
                                            input logic [31:0] pd, input int waits);
        if (TO_EN && waits >= TO) return {1'b1, 32'h0};
        return {err, (w || err) ? 32'h0 : pd};
    endfunction

    // One full transfer; starts and ends at a negedge with the DUT idle.
    task automatic xfer(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                        input int waits, input logic err, input logic [31:0] pd,
                        input int stall, input logic offer_next, input logic [ADDR_W-1:0] na);
        logic [32:0] exp_rsp;
        int          n_acc;
        exp_rsp = ref_rsp(w, err, pd, waits);
        n_acc   = (TO_EN && waits >= TO) ? TO : waits + 1;

        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);

        req_valid   = 1'b0;
        req_write   = 1'($urandom);
        req_addr    = ADDR_W'($urandom);
        req_wdata   = $urandom;
        check("setup_psel", 32'(apb_psel), 32'd1);
        check("setup_penable", 32'(apb_penable), 32'd0);
        check("setup_req_ready", 32'(req_ready), 32'd0);
        check("setup_rsp_valid", 32'(rsp_valid), 32'd0);
        check("setup_paddr", 32'(apb_paddr), 32'(a));
        check("setup_pwrite", 32'(apb_pwrite), 32'(w));
        check("setup_pwdata", apb_pwdata, d);
        apb_pready  = 1'b0;
        apb_prdata  = $urandom;
        apb_pslverr = 1'($urandom);
        rsp_ready   = 1'($urandom);
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < n_acc; i++) begin
            check("access_psel", 32'(apb_psel), 32'd1);
            check("access_penable", 32'(apb_penable), 32'd1);
            check("access_rsp_valid", 32'(rsp_valid), 32'd0);
            check("access_req_ready", 32'(req_ready), 32'd0);
            check("access_paddr", 32'(apb_paddr), 32'(a));
            check("access_pwrite", 32'(apb_pwrite), 32'(w));
            check("access_pwdata", apb_pwdata, d);
            apb_pready  = (i == waits);
            apb_prdata  = (i == waits) ? pd : $urandom;
            apb_pslverr = (i == waits) ? err : 1'($urandom);
            rsp_ready   = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end

        apb_pready  = 1'b0;
        apb_prdata  = $urandom;
        apb_pslverr = 1'($urandom);
        for (int s = 0; s <= stall; s++) begin
            check("resp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("resp_psel", 32'(apb_psel), 32'd0);
            check("resp_penable", 32'(apb_penable), 32'd0);
            check("resp_req_ready", 32'(req_ready), 32'd0);
            check("resp_rdata", rsp_rdata, exp_rsp[31:0]);
            check("resp_err", 32'(rsp_err), 32'(exp_rsp[32]));
            if (offer_next) begin
                req_valid = 1'b1;
                req_write = 1'b0;
                req_addr  = na;
            end
            rsp_ready = (s == stall);
            @(posedge clk);
            @(negedge clk);
        end

        rsp_ready = 1'b0;
        check("done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("done_req_ready", 32'(req_ready), 32'd1);
        check("done_psel", 32'(apb_psel), 32'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        rsp_ready   = 1'b0;
        apb_prdata  = '0;
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_psel", 32'(apb_psel), 32'd0);
        check("rst_penable", 32'(apb_penable), 32'd0);
        check("rst_pwrite", 32'(apb_pwrite), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_paddr", 32'(apb_paddr), 32'd0);
        check("rst_pwdata", apb_pwdata, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Zero-wait write, three-wait read, slave error read.
        xfer(1'b1, 12'h004, 32'h0000_1234, 0, 1'b0, 32'h0, 0, 1'b0, '0);
        xfer(1'b0, 12'h000, 32'h0, 3, 1'b0, 32'h0000_00A5, 1, 1'b0, '0);
        xfer(1'b0, 12'h008, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, '0);

        // Response held for 5 cycles while the next request waits.
        xfer(1'b1, 12'h00C, 32'hCAFE_0001, 2, 1'b0, 32'h0, 5, 1'b1, 12'h020);
        xfer(1'b0, 12'h020, 32'h0, 0, 1'b0, 32'h0000_55AA, 0, 1'b0, '0);

        // Long stall (times out when enabled) and pready on the limit cycle.
        xfer(1'b0, 12'h030, 32'h0, 20, 1'b0, 32'h0000_0077, 0, 1'b0, '0);
        xfer(1'b0, 12'h034, 32'h0, TO - 1, 1'b0, 32'h0000_0099, 0, 1'b0, '0);
        xfer(1'b1, 12'h038, 32'h1111_2222, TO, 1'b0, 32'h0, 0, 1'b0, '0);

        // Reset in the middle of ACCESS.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 12'h010;
        check("mid_rst_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        apb_pready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_rst_pre_penable", 32'(apb_penable), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_psel", 32'(apb_psel), 32'd0);
        check("mid_rst_penable", 32'(apb_penable), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        xfer(1'b0, 12'h010, 32'h0, 0, 1'b0, 32'h1357_9BDF, 0, 1'b0, '0);

        // Random traffic.
        for (int t = 0; t < 25; t++) begin
            xfer(1'($urandom), ADDR_W'($urandom), $urandom, int'($urandom_range(0, 10)),
                 ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)),
                 1'b0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
